pulse_train_gen: RTL

- Programmable pulse-train source. It sits directly upstream of the pulse counter stage and drives that counter's pulse input.
- It emits N pulses with a programmable high time and low time, or runs continuously until stopped.
- Every pulse is followed by at least one low cycle, so the downstream rising-edge detector sees every pulse.
- It reports busy/done to the controller and keeps a running emitted-pulse count.

---
 rtl/pulse_train_gen_pkg.sv | 22 ++
 rtl/pulse_train_gen_phase_timer.sv | 30 +++
 rtl/pulse_train_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_pkg.sv
// ppt_pkg: shared types and helpers for the pulse-train generator and its
// controller.
//   ppt_state_e   : FSM state encoding (IDLE/HIGH/LOW/DONE, 2 bits)
//   PPT_W_DEFAULT : default width of the timing/count fields
//   clamp_min1()  : max(x,1); a zero high/low time means one cycle
package ppt_pkg;

  localparam int PPT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } ppt_state_e;

  // Callers truncate the result back to their own field width.
  function automatic int unsigned clamp_min1(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// phase_timer: loadable W-bit down-counter with a zero flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val this cycle (has priority over en)
//   en       : count down by one; the counter stops at zero
//   load_val : value to load
//   cnt      : current count
//   zero     : cnt == 0
module phase_timer
  import ppt_pkg::*;
#(
  parameter int W = PPT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse-train source feeding the pulse counter.
// It emits N pulses of H high cycles and L low cycles each. N=0 runs the
// train continuously until stop. Every pulse is followed by at least one low
// cycle, so a rising-edge detector downstream sees each pulse.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a train (honoured only in IDLE, and only without stop)
//   stop         : abort the train from any non-IDLE state
//   high_cycles  : high time per pulse (0 -> 1)
//   low_cycles   : low time after each pulse (0 -> 1)
//   num_pulses   : pulse count; 0 = continuous
//   pulse_out    : registered pulse train; high exactly while in HIGH
//   busy         : state != IDLE
//   done         : one-cycle strobe in DONE (normal completion only)
//   pulse_idx    : pulses started since the last start; wraps
module pulse_train_gen
  import ppt_pkg::*;
#(
  parameter int W = PPT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] high_cycles,
  input  logic [W-1:0] low_cycles,
  input  logic [W-1:0] num_pulses,
  output logic         pulse_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pulse_idx
);

  ppt_state_e state, state_nxt;

  // Config latched at start
  logic [W-1:0] h_lat, l_lat, remaining;
  logic         cont;

  // Control from the next-state logic
  logic         tmr_load, tmr_en, start_acc, advance;
  logic [W-1:0] tmr_val;
  logic [W-1:0] tmr_cnt;
  logic         tmr_zero;

  // Clamped values straight from the inputs, used at latch time
  logic [W-1:0] h_clamp, l_clamp;
  assign h_clamp = W'(clamp_min1(32'(high_cycles)));
  assign l_clamp = W'(clamp_min1(32'(low_cycles)));

  phase_timer #(.W(W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and phase-timer control. stop beats every transition.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;
    start_acc = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_HIGH;
          start_acc = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = h_clamp - 1'b1;
        end
      end
      ST_HIGH: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (tmr_zero) begin
          state_nxt = ST_LOW;
          tmr_load  = 1'b1;
          tmr_val   = l_lat - 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (tmr_zero) begin
          if (!cont && remaining == W'(1)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_HIGH;
            advance   = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = h_lat - 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latched config, remaining-pulse count and pulse index
  always_ff @(posedge clk) begin
    if (rst) begin
      h_lat     <= '0;
      l_lat     <= '0;
      cont      <= 1'b0;
      remaining <= '0;
      pulse_idx <= '0;
    end else if (start_acc) begin
      h_lat     <= h_clamp;
      l_lat     <= l_clamp;
      cont      <= (num_pulses == '0);
      remaining <= num_pulses;
      pulse_idx <= W'(1);
    end else if (advance) begin
      // advance only fires when remaining > 1 or continuous, so no underflow
      pulse_idx <= pulse_idx + 1'b1;
      if (!cont) remaining <= remaining - 1'b1;
    end
  end

  // pulse_out is registered from the next state so it tracks state==HIGH
  // exactly, with no combinational path to the counter's edge detector.
  always_ff @(posedge clk) begin
    if (rst) pulse_out <= 1'b0;
    else     pulse_out <= (state_nxt == ST_HIGH);
  end

  // Output decode
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

endmodule
